// File: rtl/pixel_affine_map.sv
// Raster-scan source-address generator: 2x2 fixed-point affine map about (CX,CY)
// plus translation, four-stage pipeline into a show-ahead FIFO with credit-based issue.
module pixel_affine_map #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 480,
  parameter int CX         = 400,
  parameter int CY         = 240,
  parameter int COEF_W     = 12,
  parameter int FRAC       = 8,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                CLK,
  input  logic                                RESET_N,
  input  logic signed [COEF_W-1:0]            iM00,
  input  logic signed [COEF_W-1:0]            iM01,
  input  logic signed [COEF_W-1:0]            iM10,
  input  logic signed [COEF_W-1:0]            iM11,
  input  logic signed [15:0]                  iTX,
  input  logic signed [15:0]                  iTY,
  input  logic                                iCOEF_LOAD,
  input  logic                                iFLIP_V,
  input  logic                                iREAD,
  output logic [ADDR_W-1:0]                   oADDRESS,
  output logic                                oADDR_VALID,
  output logic                                oFRAME_START,
  output logic                                oREADY_N,
  output logic [$clog2(FIFO_DEPTH):0]         oFIFO_LEVEL,
  output logic                                oPENDING
);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int PW     = 16 + COEF_W;
  localparam int STAGES = 3;
  localparam int WORD_W = ADDR_W + 2;

  typedef struct packed {
    logic signed [COEF_W-1:0] m00;
    logic signed [COEF_W-1:0] m01;
    logic signed [COEF_W-1:0] m10;
    logic signed [COEF_W-1:0] m11;
    logic signed [15:0]       tx;
    logic signed [15:0]       ty;
  } coef_t;

  localparam coef_t IDENT = '{m00: COEF_W'(1 << FRAC), m01: '0, m10: '0,
                              m11: COEF_W'(1 << FRAC), tx: '0, ty: '0};

  // ---------------- scan counter, credit issue, coefficient banks
  logic [15:0]        col, row;
  coef_t              act_c, pnd_c, use_c;
  logic               pending;
  logic [STAGES:1]    vld_pipe;
  logic [LVL_W-1:0]   level;
  logic [LVL_W:0]     credit;
  logic               issue, first, swap;

  assign credit = (LVL_W+1)'(level) + (LVL_W+1)'($countones(vld_pipe));
  assign issue  = credit < (LVL_W+1)'(FIFO_DEPTH);
  assign first  = (col == '0) && (row == '0);
  assign swap   = issue && first && pending;
  // the pixel that triggers the swap already runs with the new set
  assign use_c  = swap ? pnd_c : act_c;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      col     <= '0;
      row     <= '0;
      act_c   <= IDENT;
      pnd_c   <= IDENT;
      pending <= 1'b0;
    end else begin
      if (issue) begin
        if (col == 16'(H_RES - 1)) begin
          col <= '0;
          row <= (row == 16'(V_RES - 1)) ? '0 : row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end
      if (swap) act_c <= pnd_c;
      if (iCOEF_LOAD) begin
        pnd_c   <= '{m00: iM00, m01: iM01, m10: iM10, m11: iM11, tx: iTX, ty: iTY};
        pending <= 1'b1;
      end else if (swap) begin
        pending <= 1'b0;
      end
    end
  end

  // ---------------- datapath; each entry carries its own coefficient snapshot
  logic signed [15:0]   s1_dx, s1_dy;
  coef_t                s1_c;
  logic                 s1_fs;
  logic signed [PW-1:0] s2_p00, s2_p01, s2_p10, s2_p11;
  logic signed [15:0]   s2_tx, s2_ty;
  logic                 s2_fs;
  logic signed [17:0]   s3_sx, s3_sy;
  logic                 s3_fs;
  logic signed [31:0]   sx_w, sy_w;

  always_comb begin
    sx_w = ((32'(s2_p00) + 32'(s2_p01)) >>> FRAC) + 32'(CX) + 32'(s2_tx);
    sy_w = ((32'(s2_p10) + 32'(s2_p11)) >>> FRAC) + 32'(CY) + 32'(s2_ty);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_pipe <= '0;
      s1_dx  <= '0;  s1_dy  <= '0;  s1_c   <= IDENT; s1_fs <= 1'b0;
      s2_p00 <= '0;  s2_p01 <= '0;  s2_p10 <= '0;    s2_p11 <= '0;
      s2_tx  <= '0;  s2_ty  <= '0;  s2_fs  <= 1'b0;
      s3_sx  <= '0;  s3_sy  <= '0;  s3_fs  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], issue};
      s1_dx  <= $signed(col) - 16'(CX);
      s1_dy  <= $signed(row) - 16'(CY);
      s1_c   <= use_c;
      s1_fs  <= first;
      s2_p00 <= PW'(s1_dx) * PW'(s1_c.m00);
      s2_p01 <= PW'(s1_dy) * PW'(s1_c.m01);
      s2_p10 <= PW'(s1_dx) * PW'(s1_c.m10);
      s2_p11 <= PW'(s1_dy) * PW'(s1_c.m11);
      s2_tx  <= s1_c.tx;
      s2_ty  <= s1_c.ty;
      s2_fs  <= s1_fs;
      s3_sx  <= sx_w[17:0];
      s3_sy  <= sy_w[17:0];
      s3_fs  <= s2_fs;
    end
  end

  // S4 bounds check and linear address, written straight into the FIFO
  logic signed [31:0] sx32, sy32, ry32, addr32;
  logic               s4_valid;
  logic [WORD_W-1:0]  wr_word;

  always_comb begin
    sx32     = 32'(s3_sx);
    sy32     = 32'(s3_sy);
    s4_valid = (sx32 >= 0) && (sx32 < H_RES) && (sy32 >= 0) && (sy32 < V_RES);
    ry32     = iFLIP_V ? (V_RES - 1 - sy32) : sy32;
    addr32   = ry32 * H_RES + sx32;
    wr_word  = {s3_fs, s4_valid, s4_valid ? addr32[ADDR_W-1:0] : {ADDR_W{1'b0}}};
  end

  // ---------------- show-ahead FIFO; credit issue means it can never overflow
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              push, pop, empty;
  logic [WORD_W-1:0] head;

  assign push  = vld_pipe[STAGES];
  assign empty = (level == '0);
  assign pop   = iREAD && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  assign oREADY_N     = empty;
  assign oFIFO_LEVEL  = level;
  assign oADDRESS     = empty ? '0 : head[ADDR_W-1:0];
  assign oADDR_VALID  = !empty && head[ADDR_W];
  assign oFRAME_START = !empty && head[ADDR_W+1];
  assign oPENDING     = pending;
endmodule

// File: tb/tb_pixel_affine_map.sv
// Scoreboard bench: expected FIFO words per frame are queued by the stimulus,
// a forked monitor pops and compares on every DUT pop.
module tb_pixel_affine_map;
  localparam int H = 20, V = 12, CXT = 10, CYT = 6;
  localparam int CW = 12, FR = 8, AW = 20, DEPTH = 16;
  localparam int FRAME = H * V;

  typedef struct { int m00, m01, m10, m11, tx, ty; } coef_t;

  logic                 CLK, RESET_N;
  logic signed [CW-1:0] iM00, iM01, iM10, iM11;
  logic signed [15:0]   iTX, iTY;
  logic                 iCOEF_LOAD, iFLIP_V, iREAD;
  logic [AW-1:0]        oADDRESS;
  logic                 oADDR_VALID, oFRAME_START, oREADY_N, oPENDING;
  logic [4:0]           oFIFO_LEVEL;

  pixel_affine_map #(.H_RES(H), .V_RES(V), .CX(CXT), .CY(CYT), .COEF_W(CW),
                     .FRAC(FR), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .iM00(iM00), .iM01(iM01), .iM10(iM10), .iM11(iM11), .iTX(iTX), .iTY(iTY),
    .iCOEF_LOAD(iCOEF_LOAD), .iFLIP_V(iFLIP_V), .iREAD(iREAD),
    .oADDRESS(oADDRESS), .oADDR_VALID(oADDR_VALID), .oFRAME_START(oFRAME_START),
    .oREADY_N(oREADY_N), .oFIFO_LEVEL(oFIFO_LEVEL), .oPENDING(oPENDING));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [AW+1:0] q[$];
  int vectors, miscompares, npop, seg_base;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int fdiv(input int a);
    int d, r;
    d = 1 << FR;
    r = a / d;
    if ((a % d) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  // source pixel = M * (dest - centre) + centre + T, bounds-checked and linearised
  function automatic logic [AW+1:0] exp_word(input int c, input int r, input coef_t k, input bit flip);
    int dx, dy, sx, sy, ry, a;
    bit v, fs;
    dx = c - CXT;
    dy = r - CYT;
    sx = fdiv(dx * k.m00 + dy * k.m01) + CXT + k.tx;
    sy = fdiv(dx * k.m10 + dy * k.m11) + CYT + k.ty;
    v  = (sx >= 0) && (sx < H) && (sy >= 0) && (sy < V);
    ry = flip ? (V - 1 - sy) : sy;
    a  = v ? (ry * H + sx) : 0;
    fs = (c == 0) && (r == 0);
    return {fs, v, AW'(a)};
  endfunction

  task automatic push_frame(input coef_t k, input bit flip);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        q.push_back(exp_word(c, r, k, flip));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    iCOEF_LOAD = 1'b0;
    iREAD = ($urandom_range(0, 99) < 70);
  endtask

  task automatic wait_pops(input int target);
    int n;
    n = 0;
    while ((npop - seg_base) < target && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) begin
      vectors++;
      miscompares++;
      $display("FAIL pop_timeout: got %0d pops expected %0d", npop - seg_base, target);
    end
  endtask

  task automatic load_coef(input coef_t k);
    iM00 = CW'(k.m00); iM01 = CW'(k.m01); iM10 = CW'(k.m10); iM11 = CW'(k.m11);
    iTX  = 16'(k.tx);  iTY  = 16'(k.ty);
    iCOEF_LOAD = 1'b1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_level"}, oFIFO_LEVEL, 0);
    chk({tag, "_ready_n"}, oREADY_N, 1);
    chk({tag, "_addr"}, oADDRESS, 0);
    chk({tag, "_valid"}, oADDR_VALID, 0);
    chk({tag, "_fstart"}, oFRAME_START, 0);
    chk({tag, "_pending"}, oPENDING, 0);
  endtask

  initial begin
    coef_t ident, rot, zoom, rnd;
    logic [AW+1:0] exp, got;
    vectors = 0; miscompares = 0; npop = 0; seg_base = 0;
    ident = '{256, 0, 0, 256, 0, 0};
    rot   = '{-256, 0, 0, -256, 0, 0};
    zoom  = '{128, 0, 0, 128, 0, 0};
    rnd   = '{int'($urandom_range(0, 800)) - 400, int'($urandom_range(0, 800)) - 400,
              int'($urandom_range(0, 800)) - 400, int'($urandom_range(0, 800)) - 400,
              int'($urandom_range(0, 10)) - 5,    int'($urandom_range(0, 10)) - 5};
    RESET_N = 1'b0; iREAD = 1'b0; iFLIP_V = 1'b0; iCOEF_LOAD = 1'b0;
    iM00 = '0; iM01 = '0; iM10 = '0; iM11 = '0; iTX = '0; iTY = '0;

    fork
      forever begin
        @(negedge CLK);
        if (RESET_N && !oREADY_N && iREAD) begin
          got = {oFRAME_START, oADDR_VALID, oADDRESS};
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pop: got %0h expected no entry", got);
          end else begin
            exp = q.pop_front();
            chk($sformatf("pop%0d", npop - seg_base), got, exp);
          end
          npop++;
        end
      end
    join_none

    repeat (3) @(posedge CLK);
    #1;
    chk_empty("reset");

    // segment 1: identity, backpressure, then rotate and zoom via mid-frame loads
    push_frame(ident, 1'b0);
    RESET_N = 1'b1;
    repeat (100) begin @(posedge CLK); #1; end
    chk("bp_level", oFIFO_LEVEL, DEPTH);
    chk("bp_ready_n", oREADY_N, 0);
    chk("bp_head_addr", oADDRESS, 0);
    chk("bp_head_fstart", oFRAME_START, 1);
    wait_pops(100);
    load_coef(rot);
    step();
    chk("pending_after_load", oPENDING, 1);
    push_frame(rot, 1'b0);
    wait_pops(FRAME + 20);
    chk("pending_cleared_rot", oPENDING, 0);
    wait_pops(FRAME + 100);
    load_coef(zoom);
    step();
    chk("pending_after_load2", oPENDING, 1);
    push_frame(zoom, 1'b0);
    wait_pops(2 * FRAME + 50);
    chk("pending_cleared_zoom", oPENDING, 0);

    // asynchronous reset mid-frame flushes everything and restores identity
    @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    iREAD = 1'b0;
    q.delete();
    #1;
    chk_empty("midreset");

    // segment 2: flipped addressing, identity then a random transform
    iFLIP_V = 1'b1;
    seg_base = npop;
    push_frame(ident, 1'b1);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    wait_pops(100);
    load_coef(rnd);
    step();
    push_frame(rnd, 1'b1);
    wait_pops(2 * FRAME);
    iREAD = 1'b0;
    repeat (2) @(posedge CLK);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
